// File: rtl/keypad_pkg.sv
// keypad_pkg: key index encoding, emulator states and the idle column level.
package keypad_pkg;
    localparam logic [3:0] COL_IDLE = 4'b1111;
    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} emu_state_t;
    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction
    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: scanner-side matrix lines plus the press command/status.
interface keypad_emulator_if;
    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] press_key;
    logic press_req;
    logic busy;
    logic done;
    modport master(output fila, press_req, press_key, input columna, busy, done);
    modport slave(input fila, press_req, press_key, output columna, busy, done);
endinterface

// File: rtl/keypad_emulator_contact_bounce.sv
// contact_bounce: one bounce window; contact starts at level, toggles, then settles at level.
module contact_bounce
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 20000,
    parameter int BOUNCE_TOGGLE = 2000,
    parameter int PW = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic level,
    output logic finished,
    output logic contact
);
    localparam int TW = cnt_w(BOUNCE_TOGGLE);
    logic active;
    logic lvl;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic tog;
    assign finished = active && pcnt == PW'(BOUNCE_CYCLES - 1);
    assign tog = tcnt == TW'(BOUNCE_TOGGLE - 1);
    // the contact keeps its settled level after the window, serving HOLD and GAP too
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            active  <= 1'b0;
            lvl     <= 1'b0;
            contact <= 1'b0;
            pcnt    <= '0;
            tcnt    <= '0;
        end else if (start) begin
            active  <= BOUNCE_CYCLES > 0;
            lvl     <= level;
            contact <= level;
            pcnt    <= '0;
            tcnt    <= '0;
        end else if (finished) begin
            active  <= 1'b0;
            contact <= lvl;
        end else if (active) begin
            pcnt    <= pcnt + 1'b1;
            tcnt    <= tog ? '0 : tcnt + 1'b1;
            contact <= tog ? ~contact : contact;
        end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers the row scan on the column lines as one commanded key press would.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 500000,
    parameter int BOUNCE_CYCLES = 20000,
    parameter int BOUNCE_TOGGLE = 2000,
    parameter int GAP_CYCLES    = 100000
) (
    input logic clk,
    input logic rst,
    keypad_emulator_if.slave bus
);
    localparam int M1 = HOLD_CYCLES > BOUNCE_CYCLES ? HOLD_CYCLES : BOUNCE_CYCLES;
    localparam int PW = cnt_w(M1 > GAP_CYCLES ? M1 : GAP_CYCLES);
    localparam logic SKIP = BOUNCE_CYCLES == 0;
    emu_state_t state;
    logic [PW-1:0] cnt;
    logic [3:0] key;
    logic start, finished, contact, hold_end;
    assign hold_end = state == HOLD && cnt == PW'(HOLD_CYCLES - 1);
    assign start = (state == IDLE && bus.press_req) || hold_end;
    contact_bounce #(
        .BOUNCE_CYCLES(BOUNCE_CYCLES),
        .BOUNCE_TOGGLE(BOUNCE_TOGGLE),
        .PW(PW)
    ) u_bounce (
        .clk(clk),
        .rst(rst),
        .start(start),
        .level(state == IDLE),
        .finished(finished),
        .contact(contact)
    );
    assign bus.columna = contact && !bus.fila[key_row(key)] ? ~(4'b0001 << key_col(key)) : COL_IDLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            key      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.press_req) begin
                    key      <= bus.press_key;
                    bus.busy <= 1'b1;
                    cnt      <= '0;
                    state    <= SKIP ? HOLD : BOUNCE_IN;
                end
                BOUNCE_IN: if (finished) begin
                    cnt   <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    cnt   <= hold_end ? '0 : cnt + 1'b1;
                    state <= hold_end ? (SKIP ? GAP : BOUNCE_OUT) : HOLD;
                end
                BOUNCE_OUT: if (finished) begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: if (cnt == PW'(GAP_CYCLES - 1)) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
endmodule
